usb_host_enum_fsm: RTL
======================

USB_HOST_ENUM_FSM -- requirements
Module: usb_host_enum_fsm

Interface
REQ-001 Parameter MAX_RETRY, default 3, SHALL be the number of attempts allowed per request before failure (range 1-15).
REQ-002 Parameter RECOV_CYCLES, default 16, SHALL be the post-SET_ADDRESS recovery wait in clk cycles (range 1-65535).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request to enumerate a device.
REQ-006 dev_addr  input  7  address to assign; sampled on accepted start.
REQ-007 cnfg_val  input  8  configuration value to select; sampled on accepted start.
REQ-008 txn_valid  output  1  control-transfer request to the transaction engine.
REQ-009 txn_ready  input  1  engine accepts the request while txn_valid is high.
REQ-010 txn_addr  output  7  target device address of the request.
REQ-011 txn_request  output  8  bRequest code.
REQ-012 txn_value  output  16  wValue field.
REQ-013 txn_done  input  1  one-cycle completion pulse from the engine.
REQ-014 txn_ok  input  1  qualifies txn_done: 1 = ACK, 0 = STALL/timeout.
REQ-015 busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-016 enum_done  output  1  high while in DONE.
REQ-017 enum_err  output  1  high while in ERROR.

Function
REQ-018 States SHALL be IDLE, ADDR_REQ, ADDR_WAIT, RECOV, CNFG_REQ, CNFG_WAIT, DONE and ERROR.
REQ-019 A start in IDLE, DONE or ERROR SHALL latch dev_addr and cnfg_val, clear the retry count, and enter ADDR_REQ on the next edge; a start in any other state SHALL be ignored.
REQ-020 A start with dev_addr = 0 SHALL enter ERROR directly, with no transaction issued.
REQ-021 ADDR_REQ SHALL drive txn_valid=1, txn_addr=0, txn_request=0x05, txn_value={9'b0, latched dev_addr}.
REQ-022 CNFG_REQ SHALL drive txn_valid=1, txn_addr=latched dev_addr, txn_request=0x09, txn_value={8'b0, latched cnfg_val}.
REQ-023 txn_valid and all txn_* fields SHALL remain stable until the cycle txn_ready is sampled high; the FSM SHALL then move to the matching WAIT state and deassert txn_valid.
REQ-024 In all states other than ADDR_REQ and CNFG_REQ, txn_valid SHALL be 0 and txn_addr, txn_request and txn_value SHALL be 0.
REQ-025 In a WAIT state, txn_done with txn_ok=1 SHALL advance the FSM: ADDR_WAIT goes to RECOV, and CNFG_WAIT goes to DONE.
REQ-026 In a WAIT state, txn_done with txn_ok=0 SHALL increment the retry count.
REQ-027 After that increment, the FSM SHALL enter ERROR if the count equals MAX_RETRY; otherwise it SHALL re-enter the same phase's REQ state.
REQ-028 The retry count SHALL clear on entry to RECOV, so that each request has its own MAX_RETRY budget.
REQ-029 txn_done outside a WAIT state SHALL be ignored.
REQ-030 RECOV SHALL last exactly RECOV_CYCLES cycles, using a 16-bit down-counter, then enter CNFG_REQ; start is ignored during RECOV.
REQ-031 DONE and ERROR SHALL hold until the next start (REQ-019) or reset.
REQ-032 The FSM SHALL have no other exits: no timeout of its own, and a WAIT state waits indefinitely for txn_done.

Reset
REQ-033 rst high SHALL immediately force IDLE, zero the retry and recovery counters, the latched address and the latched configuration, and drive every output to 0.
REQ-034 A reset asserted mid-transaction SHALL abandon the transaction without any further output activity.
REQ-035 After rst deasserts, the FSM SHALL remain in IDLE until a start is received.

Verification
REQ-036 Happy path: start with dev_addr=0x12 and cnfg_val=0x01, engine ready at once, txn_ok=1 -> first request (0, 0x05, 0x0012), exactly 16 RECOV cycles, second request (0x12, 0x09, 0x0001), then enum_done=1.
REQ-037 Backpressure: txn_ready held low for 5 cycles in ADDR_REQ -> txn_valid and fields stable for all 5 cycles, accepted on the 6th.
REQ-038 Retry: SET_ADDRESS fails twice then succeeds (MAX_RETRY=3) -> three identical requests, then RECOV; a subsequent CNFG failure is still allowed 3 attempts.
REQ-039 Exhaustion: SET_CONFIGURATION fails 3 times -> ERROR with enum_err=1 and busy=0; a new start restarts from ADDR_REQ.
REQ-040 Boundaries: start with dev_addr=0 -> ERROR with no txn_valid; start during CNFG_WAIT -> ignored; stray txn_done in IDLE -> no effect.
REQ-041 Reset: rst asserted during RECOV -> all outputs 0 without waiting for a clock edge; after release, the FSM stays in IDLE until start.

Source files
------------

// File: rtl/usb_host_enum_if.sv
// usb_host_enum_if: control/status and transaction-engine handshake bundle for usb_host_enum_fsm
interface usb_host_enum_if;
  logic        start;
  logic [6:0]  dev_addr;
  logic [7:0]  cnfg_val;
  logic        txn_valid;
  logic        txn_ready;
  logic [6:0]  txn_addr;
  logic [7:0]  txn_request;
  logic [15:0] txn_value;
  logic        txn_done;
  logic        txn_ok;
  logic        busy;
  logic        enum_done;
  logic        enum_err;
  modport master (
    input  start, dev_addr, cnfg_val, txn_ready, txn_done, txn_ok,
    output txn_valid, txn_addr, txn_request, txn_value, busy, enum_done, enum_err
  );
  modport slave (
    output start, dev_addr, cnfg_val, txn_ready, txn_done, txn_ok,
    input  txn_valid, txn_addr, txn_request, txn_value, busy, enum_done, enum_err
  );
endinterface

// File: rtl/usb_host_enum_fsm.sv
// usb_host_enum_fsm: SET_ADDRESS, recovery wait, SET_CONFIGURATION sequencer with per-request retry budget
module usb_host_enum_fsm #(
  parameter int MAX_RETRY    = 3,
  parameter int RECOV_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  usb_host_enum_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR_REQ, ADDR_WAIT, RECOV, CNFG_REQ, CNFG_WAIT, DONE, ERROR} state_t;
  state_t      state, state_n;
  logic [3:0]  retry, retry_n;
  logic [15:0] rcnt, rcnt_n;
  logic [6:0]  addr_q, addr_n;
  logic [7:0]  cnfg_q, cnfg_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      retry  <= '0;
      rcnt   <= '0;
      addr_q <= '0;
      cnfg_q <= '0;
    end else begin
      state  <= state_n;
      retry  <= retry_n;
      rcnt   <= rcnt_n;
      addr_q <= addr_n;
      cnfg_q <= cnfg_n;
    end
  end
  always_comb begin
    state_n = state;
    retry_n = retry;
    rcnt_n  = rcnt;
    addr_n  = addr_q;
    cnfg_n  = cnfg_q;
    case (state)
      IDLE, DONE, ERROR:
        if (bus.start) begin
          addr_n  = bus.dev_addr;
          cnfg_n  = bus.cnfg_val;
          retry_n = '0;
          state_n = (bus.dev_addr == '0) ? ERROR : ADDR_REQ;
        end
      ADDR_REQ: state_n = bus.txn_ready ? ADDR_WAIT : ADDR_REQ;
      CNFG_REQ: state_n = bus.txn_ready ? CNFG_WAIT : CNFG_REQ;
      ADDR_WAIT, CNFG_WAIT:
        if (bus.txn_done && bus.txn_ok) begin
          state_n = (state == ADDR_WAIT) ? RECOV : DONE;
          retry_n = (state == ADDR_WAIT) ? '0 : retry;
          rcnt_n  = 16'(RECOV_CYCLES - 1);
        end else if (bus.txn_done) begin
          retry_n = retry + 4'd1;
          state_n = (retry_n == 4'(MAX_RETRY)) ? ERROR : (state == ADDR_WAIT) ? ADDR_REQ : CNFG_REQ;
        end
      RECOV: begin
        state_n = (rcnt == '0) ? CNFG_REQ : RECOV;
        rcnt_n  = (rcnt == '0) ? rcnt : rcnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // request fields are pure decodes of state, so reset clears them without a clock edge
  assign bus.txn_valid   = (state == ADDR_REQ) || (state == CNFG_REQ);
  assign bus.txn_addr    = (state == CNFG_REQ) ? addr_q : '0;
  assign bus.txn_request = (state == ADDR_REQ) ? 8'h05 : (state == CNFG_REQ) ? 8'h09 : 8'h00;
  assign bus.txn_value   = (state == ADDR_REQ) ? {9'b0, addr_q} : (state == CNFG_REQ) ? {8'b0, cnfg_q} : 16'h0;
  assign bus.busy        = !((state == IDLE) || (state == DONE) || (state == ERROR));
  assign bus.enum_done   = (state == DONE);
  assign bus.enum_err    = (state == ERROR);
endmodule
